// File: rtl/instr_encode_loader.sv
// Packs instruction field bundles into 16-bit ISA words and writes them to instruction RAM.
// When VERIFY is set, each word is read back and compared before it counts as committed.
module instr_encode_loader #(
  parameter int ADDR_W = 8,
  parameter bit VERIFY = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_rs1,
  input  logic [3:0]        in_rs2,
  input  logic [3:0]        in_ra,
  input  logic [7:0]        in_imm,
  input  logic              in_last,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err_verify,
  output logic              err_full,
  output logic [ADDR_W:0]   words_written
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t      r_state;
  logic        r_last;
  logic [15:0] w_word;
  logic        w_commit;
  logic        w_mismatch;

  // Opcodes 5, 7 and 8 carry an 8-bit immediate; everything else is register form.
  function automatic logic [15:0] encode_word(input logic [3:0] op, input logic [3:0] rs1,
                                              input logic [3:0] rs2, input logic [3:0] ra,
                                              input logic [7:0] imm);
    logic [15:0] word;
    case (op)
      4'd5, 4'd7, 4'd8: word = {op, rs1, imm};
      default:          word = {op, rs1, rs2, ra};
    endcase
    return word;
  endfunction

  assign w_word = encode_word(in_op, in_rs1, in_rs2, in_ra, in_imm);

  // Commit point: end of WRITE without read-back, or a matching CHECK with it.
  always_comb begin
    w_commit   = 1'b0;
    w_mismatch = 1'b0;
    if ((r_state == S_WRITE) && !VERIFY) begin
      w_commit = 1'b1;
    end else if (r_state == S_CHECK) begin
      w_mismatch = (mem_rdata != mem_wdata);
      w_commit   = (mem_rdata == mem_wdata);
    end else begin
      w_commit = 1'b0;
    end
  end

  // Loader FSM with all outputs registered; mem_wdata doubles as the latched word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last        <= 1'b0;
      in_ready      <= 1'b1;
      mem_we        <= 1'b0;
      mem_re        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 16'h0000;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_verify    <= 1'b0;
      err_full      <= 1'b0;
      words_written <= '0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_state   <= S_WRITE;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            mem_we    <= 1'b1;
            mem_wdata <= w_word;
            r_last    <= in_last;
          end
        end
        S_WRITE: begin
          if (VERIFY) begin
            r_state <= S_READ;
            mem_re  <= 1'b1;
          end else begin
            r_state <= S_WRITE;
          end
        end
        S_READ:  r_state <= S_CHECK;
        S_CHECK: begin
          if (w_mismatch) begin
            r_state    <= S_ERR;
            err_verify <= 1'b1;
          end
        end
        S_DONE, S_ERR: begin
          if (restart) begin
            r_state       <= S_IDLE;
            in_ready      <= 1'b1;
            busy          <= 1'b0;
            mem_addr      <= '0;
            words_written <= '0;
            done          <= 1'b0;
            err_verify    <= 1'b0;
            err_full      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_commit) begin
        words_written <= words_written + (ADDR_W+1)'(1'b1);
        if (r_last) begin
          r_state <= S_DONE;
          done    <= 1'b1;
          busy    <= 1'b0;
        end else if (mem_addr == LAST_ADDR) begin
          r_state  <= S_ERR;
          err_full <= 1'b1;
        end else begin
          mem_addr <= mem_addr + ADDR_W'(1'b1);
          r_state  <= S_IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Randomized bench for instr_encode_loader: a 4-word verifying instance and a 16-word
// non-verifying instance, both checked against a word-level reference model.
module tb_instr_encode_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, restart, sel, corrupt;
  logic [3:0] op, rs1, rs2, ra;
  logic [7:0] imm;
  logic       last;

  logic        a_ready, a_we, a_re, a_busy, a_done, a_ev, a_ef;
  logic [1:0]  a_addr;
  logic [15:0] a_wdata, a_rdata;
  logic [2:0]  a_ww;
  logic        b_ready, b_we, b_re, b_busy, b_done, b_ev, b_ef;
  logic [3:0]  b_addr;
  logic [15:0] b_wdata, b_rdata;
  logic [4:0]  b_ww;

  logic [15:0] mem_a [0:3];

  instr_encode_loader #(.ADDR_W(2), .VERIFY(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(a_ready),
    .in_op(op), .in_rs1(rs1), .in_rs2(rs2), .in_ra(ra), .in_imm(imm), .in_last(last),
    .restart(restart & ~sel), .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
    .mem_re(a_re), .mem_rdata(a_rdata), .busy(a_busy), .done(a_done),
    .err_verify(a_ev), .err_full(a_ef), .words_written(a_ww));

  instr_encode_loader #(.ADDR_W(4), .VERIFY(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(b_ready),
    .in_op(op), .in_rs1(rs1), .in_rs2(rs2), .in_ra(ra), .in_imm(imm), .in_last(last),
    .restart(restart & sel), .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
    .mem_re(b_re), .mem_rdata(b_rdata), .busy(b_busy), .done(b_done),
    .err_verify(b_ev), .err_full(b_ef), .words_written(b_ww));

  assign b_rdata = 16'h0000;

  // Instruction RAM for instance A; corrupt forces a zero read-back.
  always @(posedge clk) begin
    if (a_we) mem_a[a_addr] <= a_wdata;
    if (a_re) a_rdata <= corrupt ? 16'h0000 : mem_a[a_addr];
  end

  logic        o_ready, o_we, o_re, o_busy, o_done, o_ev, o_ef;
  logic [3:0]  o_addr;
  logic [15:0] o_wdata;
  logic [4:0]  o_ww;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_we    = sel ? b_we    : a_we;
  assign o_re    = sel ? b_re    : a_re;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_ev    = sel ? b_ev    : a_ev;
  assign o_ef    = sel ? b_ef    : a_ef;
  assign o_addr  = sel ? b_addr  : {2'b00, a_addr};
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_ww    = sel ? b_ww    : {2'b00, a_ww};

  int n_vec = 0;
  int n_bad = 0;
  int m_addr [2];
  int m_cnt  [2];
  bit m_halt [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (dut %0d): got %0h expected %0h", tag, sel, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_word(input logic [3:0] f_op, input logic [3:0] f_rs1,
                                           input logic [3:0] f_rs2, input logic [3:0] f_ra,
                                           input logic [7:0] f_imm);
    if (f_op inside {4'd5, 4'd7, 4'd8}) return {f_op, f_rs1, f_imm};
    return {f_op, f_rs1, f_rs2, f_ra};
  endfunction

  task automatic check_outputs(input string tag, input bit e_ready, input bit e_busy,
                               input bit e_done, input bit e_ev, input bit e_ef, input int s);
    check_val({tag, "_ready"}, 32'(o_ready), 32'(e_ready));
    check_val({tag, "_busy"},  32'(o_busy),  32'(e_busy));
    check_val({tag, "_done"},  32'(o_done),  32'(e_done));
    check_val({tag, "_errv"},  32'(o_ev),    32'(e_ev));
    check_val({tag, "_errf"},  32'(o_ef),    32'(e_ef));
    check_val({tag, "_addr"},  32'(o_addr),  32'(m_addr[s]));
    check_val({tag, "_count"}, 32'(o_ww),    32'(m_cnt[s]));
  endtask

  task automatic send(input logic [3:0] f_op, input logic [3:0] f_rs1, input logic [3:0] f_rs2,
                      input logic [3:0] f_ra, input logic [7:0] f_imm, input bit f_last,
                      input bit f_bad);
    int s, depth, waited;
    logic [15:0] w;
    bit mis;
    s = sel ? 1 : 0;
    depth = sel ? 16 : 4;
    w = ref_word(f_op, f_rs1, f_rs2, f_ra, f_imm);
    waited = 0;
    while (!o_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check_val("ready_wait", 32'(o_ready), 32'd1);
    if (!o_ready) return;
    op = f_op; rs1 = f_rs1; rs2 = f_rs2; ra = f_ra; imm = f_imm; last = f_last;
    corrupt = f_bad; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check_val("wr_we",    32'(o_we),    32'd1);
    check_val("wr_re",    32'(o_re),    32'd0);
    check_val("wr_addr",  32'(o_addr),  32'(m_addr[s]));
    check_val("wr_wdata", 32'(o_wdata), 32'(w));
    check_val("wr_ready", 32'(o_ready), 32'd0);
    if (s == 0) begin
      @(negedge clk);
      check_val("rd_we",   32'(o_we),   32'd0);
      check_val("rd_re",   32'(o_re),   32'd1);
      check_val("rd_addr", 32'(o_addr), 32'(m_addr[s]));
      @(negedge clk);
      check_val("ck_strobes", 32'({o_we, o_re}), 32'd0);
    end
    @(negedge clk);
    corrupt = 1'b0;
    mis = (s == 0) && f_bad && (w != 16'h0000);
    if (mis) begin
      m_halt[s] = 1'b1;
      check_outputs("verr", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, s);
    end else begin
      m_cnt[s]++;
      if (f_last) begin
        m_halt[s] = 1'b1;
        check_outputs("done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, s);
      end else if (m_addr[s] == depth - 1) begin
        m_halt[s] = 1'b1;
        check_outputs("full", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, s);
      end else begin
        m_addr[s]++;
        check_outputs("next", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, s);
      end
    end
  endtask

  task automatic do_restart();
    int s;
    s = sel ? 1 : 0;
    restart = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    in_valid = 1'b0;
    m_addr[s] = 0; m_cnt[s] = 0; m_halt[s] = 1'b0;
    check_val("rs_we", 32'(o_we), 32'd0);
    check_outputs("restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, s);
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 0; m_cnt[i] = 0; m_halt[i] = 1'b0;
    end
  endtask

  // Structural invariants sampled every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check_val("b_never_reads", 32'(b_re), 32'd0);
      check_val("a_we_re_excl",  32'(a_we & a_re), 32'd0);
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; restart = 1'b0; sel = 1'b0; corrupt = 1'b0;
    op = 4'h0; rs1 = 4'h0; rs2 = 4'h0; ra = 4'h0; imm = 8'h00; last = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      sel = i[0];
      #1;
      check_val("rst_we",    32'({o_we, o_re}), 32'd0);
      check_val("rst_wdata", 32'(o_wdata), 32'd0);
      check_outputs("rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i);
    end
    sel = 1'b0;
    #1;
    rst = 1'b0;

    // Immediate form then a final load word.
    send(4'd5, 4'd3, 4'hF, 4'hF, 8'h7F, 1'b0, 1'b0);
    send(4'd9, 4'd1, 4'd2, 4'd3, 8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check_val("hold_we", 32'(o_we), 32'd0);
      check_outputs("hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    end
    in_valid = 1'b0;
    do_restart();

    // Register form, then a word whose read-back comes back as zero.
    send(4'd1, 4'd2, 4'd4, 4'd6, 8'h00, 1'b0, 1'b0);
    send(4'd10, 4'd4, 4'd5, 4'd6, 8'h00, 1'b0, 1'b1);
    do_restart();

    // Exhaust the 4-word memory, then a program ending exactly on the last word.
    for (int i = 0; i < 4; i++) send(4'(i), 4'(i + 1), 4'(i + 2), 4'(i + 3), 8'h00, 1'b0, 1'b0);
    do_restart();
    for (int i = 0; i < 4; i++) send(4'd7, 4'(i), 4'h0, 4'h0, 8'(8'h80 + i), i == 3, 1'b0);
    do_restart();

    // Reset while the read strobe is out.
    send(4'd2, 4'd1, 4'd1, 4'd1, 8'h00, 1'b0, 1'b0);
    op = 4'd3; rs1 = 4'd9; rs2 = 4'd8; ra = 4'd7; last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_val("pre_rst_re", 32'(o_re), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    check_val("rst_mid_we", 32'({o_we, o_re}), 32'd0);
    check_val("rst_mid_wdata", 32'(o_wdata), 32'd0);
    check_outputs("rst_mid", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send(4'd4, 4'd5, 4'd6, 4'd7, 8'h00, 1'b0, 1'b0);

    // Non-verifying instance: back-to-back stream.
    sel = 1'b1;
    #1;
    for (int i = 0; i < 7; i++) send(4'(i + 8), 4'(i), 4'(15 - i), 4'(i + 1), 8'(i * 17), i == 6, 1'b0);
    do_restart();

    // Random traffic on both instances.
    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 1) == 1;
      #1;
      if (m_halt[sel ? 1 : 0]) do_restart();
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Encodes instruction field bundles into the 16-bit ISA word format and writes them sequentially into instruction memory.
- Optionally reads back each word and compares it against the encoded value.
- Sits between the program source (UART/host front end or test sequencer) and the instruction RAM that feeds fetch/decode.
- Its output must round-trip through the decoder bit-exactly.

Parameters:
ADDR_W, 8, instruction memory address width; depth = 2**ADDR_W words
VERIFY, 1, 1 = read back and compare each word; 0 = skip the read-back states

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  field bundle valid
in_ready  out  1  loader can accept a bundle
in_op  in  4  opcode
in_rs1  in  4  source register 1
in_rs2  in  4  source register 2 (register form only)
in_ra  in  4  destination register (register form only)
in_imm  in  8  immediate (immediate form only); bit 7 doubles as branch mode (1 = equal, 0 = not equal)
in_last  in  1  bundle is the final word of the program
restart  in  1  single-cycle pulse; leaves DONE or ERR and rewinds to address 0
mem_we  out  1  memory write strobe
mem_addr  out  ADDR_W  write/read address
mem_wdata  out  16  encoded word
mem_re  out  1  memory read strobe
mem_rdata  in  16  read data, valid exactly one cycle after mem_re
busy  out  1  high in any state other than IDLE and DONE
done  out  1  program loaded, level
err_verify  out  1  read-back mismatch, sticky
err_full  out  1  memory exhausted before in_last, sticky
words_written  out  ADDR_W+1  count of committed words

Behaviour:
- Reset values: every output is 0, except in_ready = 1. State = IDLE, address = 0.
- Encoding:
  - word[15:12] = in_op; word[11:8] = in_rs1.
  - Immediate form (in_op = 5, 7 or 8): word[7:0] = in_imm.
  - All other opcodes, including 9 (load) and 10 (store): word[7:4] = in_rs2, word[3:0] = in_ra.
  - Any unused input fields are ignored.
  - The encoded word and in_last are captured in registers on accept.
- FSM states: IDLE, WRITE, READ, CHECK, DONE, ERR.
- IDLE: in_ready = 1. On in_valid & in_ready (accept at edge k) go to WRITE.
- WRITE (cycle k+1): mem_we = 1, mem_addr = current address, mem_wdata = latched word.
  - If VERIFY = 0, the word commits here.
  - If VERIFY = 1, go to READ.
- READ (k+2): mem_re = 1, same address.
- CHECK (k+3): compare mem_rdata with the latched word.
  - Mismatch: err_verify = 1, go to ERR. The word does not commit.
  - Match: the word commits.
- Commit:
  - words_written increments.
  - If the latched in_last is set, go to DONE, done = 1, address unchanged.
  - Else if address = 2**ADDR_W - 1, set err_full = 1 and go to ERR.
  - Otherwise address increments and the FSM returns to IDLE.
- Throughput: VERIFY = 1 gives one word per 4 cycles (in_ready back high at k+4). VERIFY = 0 gives one word per 2 cycles.
- A last word written to the final address goes to DONE, not ERR.
- in_ready is 0 in WRITE, READ, CHECK, DONE and ERR. Bundles offered then are not consumed; the source must hold them.
- DONE and ERR hold all flags and outputs until restart or rst. In ERR, mem_addr holds the failing address.
- restart in DONE or ERR: next cycle IDLE, address = 0, words_written = 0, done/err flags cleared. restart in any other state is ignored.
- in_valid coincident with restart: not accepted that cycle; in_ready rises the following cycle.
- rst mid-operation (any state) returns to IDLE with reset values on the next edge. A write not yet strobed is dropped; no partial strobes occur after the reset edge.
- mem_we and mem_re are never high in the same cycle. Both are single-cycle per word.

Test Plan:
- Register form: op=1, rs1=2, rs2=4, ra=6, last=0 -> mem_we at k+1, addr 0, wdata 0x1246; in_ready high at k+4; words_written = 1.
- Immediate form: op=5, rs1=3, imm=0x7F, rs2/ra=0xF (ignored) -> wdata 0x537F. Next bundle op=9, rs1=1, rs2=2, ra=3, last=1 -> addr 1, wdata 0x9123, done = 1, words_written = 2, in_ready = 0.
- Verify fail: memory model returns 0x0000 for a word encoded 0xA456 -> err_verify = 1 at k+4, state ERR, words_written unchanged; restart -> flags clear, addr 0, in_ready = 1.
- Full (ADDR_W=2): stream 4 bundles with last=0 -> err_full after the 4th commit, words_written = 4; a 4-word stream with last on the 4th -> done instead.
- VERIFY=0: back-to-back valid bundles -> one mem_we every 2 cycles, mem_re never asserted.
- rst asserted during READ -> next cycle all outputs 0, in_ready = 1, a following bundle writes to addr 0.
